// File: rtl/regsr_banked_pkg.sv
// Shared definitions for the banked special-register file: SR indices,
// the stack-pointer reset value and the save/restore sequencer states.
package regsr_banked_pkg;

    localparam int SR_IDX_STATUS = 0;
    localparam int SR_IDX_EPC    = 1;
    localparam int SR_IDX_ECAUSE = 2;
    localparam int SR_IDX_SSP    = 7;

    localparam logic [47:0] SR_SSP_RST = 48'h000000000FFF;

    typedef enum logic [1:0] {
        REGSR_ST_IDLE    = 2'd0,
        REGSR_ST_SAVE    = 2'd1,
        REGSR_ST_RESTORE = 2'd2
    } regsr_state_e;

endpackage

// File: rtl/regsr_seq.sv
// Save/restore sequencer: walks one register index per cycle and reports
// which direction the bank copy runs, plus busy/done handshakes.
module regsr_seq
    import regsr_banked_pkg::*;
#(
    parameter int P_DEPTH  = 16,
    parameter int P_ADDR_W = $clog2(P_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                save_i,
    input  logic                restore_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                copy_en_o,
    output logic                copy_save_o,
    output logic [P_ADDR_W-1:0] copy_idx_o
);

    regsr_state_e          state_q, state_d;
    logic [P_ADDR_W-1:0]   cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= REGSR_ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        copy_en_o   = 1'b0;
        copy_save_o = 1'b0;
        unique case (state_q)
            REGSR_ST_IDLE: begin
                cnt_d = '0;
                if (save_i)         state_d = REGSR_ST_SAVE;
                else if (restore_i) state_d = REGSR_ST_RESTORE;
            end
            REGSR_ST_SAVE, REGSR_ST_RESTORE: begin
                copy_en_o   = 1'b1;
                copy_save_o = (state_q == REGSR_ST_SAVE);
                // Counter wraps back to zero on the last copy.
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == P_ADDR_W'(P_DEPTH - 1)) begin
                    state_d = REGSR_ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = REGSR_ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q != REGSR_ST_IDLE);
    assign done_o     = done_q;
    assign copy_idx_o = cnt_q;

endmodule

// File: rtl/regsr_banked.sv
// Special-register file with two read ports, one write port, an adjust
// port and a shadow bank for trap context save/restore.
module regsr_banked
    import regsr_banked_pkg::*;
#(
    parameter int                 P_WIDTH   = 48,
    parameter int                 P_DEPTH   = 16,
    parameter int                 P_ADDR_W  = $clog2(P_DEPTH),
    parameter int                 P_SSP_IDX = SR_IDX_SSP,
    parameter logic [P_WIDTH-1:0] P_SSP_RST = P_WIDTH'(SR_SSP_RST),
    parameter bit                 P_BYPASS  = 1'b1
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic [P_ADDR_W-1:0] iw_read_addr1,
    input  logic [P_ADDR_W-1:0] iw_read_addr2,
    output logic [P_WIDTH-1:0]  ow_read_data1,
    output logic [P_WIDTH-1:0]  ow_read_data2,
    input  logic                iw_write_enable,
    input  logic [P_ADDR_W-1:0] iw_write_addr,
    input  logic [P_WIDTH-1:0]  iw_write_data,
    input  logic                iw_adj_enable,
    input  logic [P_ADDR_W-1:0] iw_adj_addr,
    input  logic [P_WIDTH-1:0]  iw_adj_delta,
    input  logic                iw_save,
    input  logic                iw_restore,
    output logic                ow_busy,
    output logic                ow_done
);

    logic [P_WIDTH-1:0]  live_q   [P_DEPTH];
    logic [P_WIDTH-1:0]  live_d   [P_DEPTH];
    logic [P_WIDTH-1:0]  shadow_q [P_DEPTH];
    logic [P_WIDTH-1:0]  shadow_d [P_DEPTH];
    logic                copy_en, copy_save;
    logic [P_ADDR_W-1:0] copy_idx;
    logic                wr_fwd;

    regsr_seq #(.P_DEPTH(P_DEPTH), .P_ADDR_W(P_ADDR_W)) u_seq (
        .clk_i       (iw_clk),
        .rst_i       (iw_rst),
        .save_i      (iw_save),
        .restore_i   (iw_restore),
        .busy_o      (ow_busy),
        .done_o      (ow_done),
        .copy_en_o   (copy_en),
        .copy_save_o (copy_save),
        .copy_idx_o  (copy_idx)
    );

    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        if (copy_en) begin
            if (copy_save) shadow_d[copy_idx] = live_q[copy_idx];
            else           live_d[copy_idx]   = shadow_q[copy_idx];
        end else if (!ow_busy) begin
            if (iw_adj_enable)
                live_d[iw_adj_addr] = live_q[iw_adj_addr] + iw_adj_delta;
            // Applied after the adjust so a same-index write wins.
            if (iw_write_enable)
                live_d[iw_write_addr] = iw_write_data;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                live_q[i]   <= (i == P_SSP_IDX) ? P_SSP_RST : '0;
                shadow_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign wr_fwd = P_BYPASS && iw_write_enable && !ow_busy;

    assign ow_read_data1 = (wr_fwd && iw_read_addr1 == iw_write_addr) ? iw_write_data
                                                                      : live_q[iw_read_addr1];
    assign ow_read_data2 = (wr_fwd && iw_read_addr2 == iw_write_addr) ? iw_write_data
                                                                      : live_q[iw_read_addr2];

endmodule
